add_round_key: RTL and testbench



---
 rtl/add_round_key.sv | 44 ++++
 tb/tb_add_round_key.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/add_round_key.sv
// AES-128 AddRoundKey: registered 128-bit state ^ round key in 16 byte lanes; 1-cycle latency.
// No backpressure: every IN_valid sample is accepted. ADD_ROUND_KEY_CLEAR_ON_IDLE_EN zeroes OUT_state on idle cycles.
module add_round_key (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         IN_valid,
    input  logic [127:0] IN_state,
    input  logic [127:0] RoundKey,
    output logic         OUT_valid,
    output logic [127:0] OUT_state
);

    logic [127:0] lane_xor;

    // Byte b = col*4 + row sits at [127-8b -: 8] (FIPS-197 column-major order).
    genvar col, row;
    generate
        for (col = 0; col < 4; col++) begin : g_col
            for (row = 0; row < 4; row++) begin : g_row
                localparam int B = col * 4 + row;
                assign lane_xor[127-8*B -: 8] = IN_state[127-8*B -: 8] ^ RoundKey[127-8*B -: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            OUT_valid <= 1'b0;
            OUT_state <= '0;
        end else begin
            OUT_valid <= IN_valid;
            if (IN_valid) begin
                OUT_state <= lane_xor;
            end else begin
`ifdef ADD_ROUND_KEY_CLEAR_ON_IDLE_EN
                OUT_state <= '0;
`else
                OUT_state <= OUT_state;
`endif
            end
        end
    end

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: scoreboard of expected outputs, sampled on the falling edge.
module tb_add_round_key;

    logic         clk;
    logic         reset_n;
    logic         IN_valid;
    logic [127:0] IN_state;
    logic [127:0] RoundKey;
    logic         OUT_valid;
    logic [127:0] OUT_state;

    typedef struct packed {
        logic         v;
        logic [127:0] s;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] exp_st;
    int           checks;
    int           failures;

    localparam logic [127:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] ID_S   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ONES   = {128{1'b1}};

    add_round_key dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .IN_valid  (IN_valid),
        .IN_state  (IN_state),
        .RoundKey  (RoundKey),
        .OUT_valid (OUT_valid),
        .OUT_state (OUT_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end
    endtask

    // Drive one cycle at a falling edge, check its result at the next falling edge.
    task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k, input string tag);
        exp_t e;
        if (v) begin
            exp_st = s ^ k;
        end else begin
`ifdef ADD_ROUND_KEY_CLEAR_ON_IDLE_EN
            exp_st = '0;
`else
            exp_st = exp_st;
`endif
        end
        e.v = v;
        e.s = exp_st;
        sb.push_back(e);
        IN_valid = v;
        IN_state = s;
        RoundKey = k;
        @(posedge clk);
        #1;
        IN_state = rnd128();
        RoundKey = rnd128();
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'd1, 128'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, {127'd0, OUT_valid}, {127'd0, e.v});
            check({tag, "_state"}, OUT_state, e.s);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_st   = '0;
        reset_n  = 1'b0;
        IN_valid = 1'b1;
        IN_state = rnd128();
        RoundKey = rnd128();

        // Reset held with live random inputs: outputs stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_valid", {127'd0, OUT_valid}, 128'd0);
            check("rst_state", OUT_state, 128'd0);
            IN_state = rnd128();
            RoundKey = rnd128();
        end
        IN_valid = 1'b0;
        reset_n  = 1'b1;

        drive(1'b1, FIPS_S, FIPS_K, "fips");
        drive(1'b0, rnd128(), rnd128(), "idle1");
        drive(1'b0, rnd128(), rnd128(), "idle2");
        drive(1'b1, ID_S, 128'd0, "key_zero");
        drive(1'b1, ID_S, ID_S, "key_eq_state");
        drive(1'b1, FIPS_S, FIPS_K, "b2b_fips");
        drive(1'b1, ONES, 128'd0, "b2b_ones_state");
        drive(1'b1, 128'd0, ONES, "b2b_ones_key");
        drive(1'b0, 128'd0, 128'd0, "b2b_end");

        // Asynchronous reset between edges after a valid output.
        drive(1'b1, FIPS_S, FIPS_K, "pre_arst");
        IN_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        exp_st  = '0;
        #1;
        check("arst_valid", {127'd0, OUT_valid}, 128'd0);
        check("arst_state", OUT_state, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, rnd128() , 128'd0, "post_arst");

        // Mid-stream reset: block captured, then reset pulsed before the next edge.
        IN_valid = 1'b1;
        IN_state = rnd128();
        RoundKey = rnd128();
        @(posedge clk);
        #2;
        reset_n  = 1'b0;
        IN_valid = 1'b0;
        exp_st   = '0;
        #1;
        check("mid_rst_valid", {127'd0, OUT_valid}, 128'd0);
        check("mid_rst_state", OUT_state, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_no_pulse", {127'd0, OUT_valid}, 128'd0);
        check("mid_rst_state2", OUT_state, 128'd0);
        drive(1'b1, FIPS_S, FIPS_K, "after_mid_rst");
        for (int i = 0; i < 6; i++) begin
            drive(($urandom & 1) == 1, rnd128(), rnd128(), "random");
        end
        drive(1'b0, 128'd0, 128'd0, "final_idle");

        if (sb.size() != 0) check("sb_leftover", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
